// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM (1-cycle registered read) among NREQ requesters.
// Optional exclusive-lock mode with timeout is enabled by defining SRAM_ARB_LOCK_EN.
module sram_rr_arbiter #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 1024,
  parameter  int NREQ     = 4,
  parameter  int LOCK_MAX = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_wr_data,
  input  logic [WIDTH-1:0]      mem_rd_data
`ifdef SRAM_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]       lock,
  output logic                  lock_timeout
`endif
);

  if (NREQ < 2 || NREQ > 16 || LOCK_MAX < 2) begin : g_bad_params
    $error("sram_rr_arbiter: NREQ must be 2..16 and LOCK_MAX at least 2");
  end

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             mem_wren_q, mem_wren_d;
  logic             mem_rden_q, mem_rden_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic             rd1_v_q, rd1_v_d;
  logic [IW-1:0]    rd1_id_q, rd1_id_d;
  logic             rd2_v_q, rd2_v_d;
  logic [IW-1:0]    rd2_id_q, rd2_id_d;

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  gnt_rr;
  logic [IW-1:0]    gnt_id;
  logic [IW-1:0]    cand;
  logic             found;
  logic             xfer;
  logic             gnt_we;

`ifdef SRAM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          lock_timeout_q, lock_timeout_d;
`endif

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      addr_arr[k]  = addr[k*AW +: AW];
      wdata_arr[k] = wdata[k*WIDTH +: WIDTH];
    end
  end

  // While locked, only the owner may compete; everyone else simply waits.
  always_comb begin
    eligible = req;
`ifdef SRAM_ARB_LOCK_EN
    if (state_q == LOCKED) begin
      eligible          = '0;
      eligible[owner_q] = req[owner_q];
    end
`endif
  end

  always_comb begin
    gnt_rr = '0;
    gnt_id = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && eligible[cand]) begin
        gnt_rr[cand] = 1'b1;
        gnt_id       = cand;
        found        = 1'b1;
      end
    end
  end

  assign gnt    = rst ? '0 : gnt_rr;
  assign xfer   = found & ~rst;
  assign gnt_we = we[gnt_id];

  // wren and rden come from complementary values of one we bit, so they can never both be set.
  always_comb begin
    ptr_d         = ptr_q;
    mem_wren_d    = 1'b0;
    mem_rden_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd1_v_d       = 1'b0;
    rd1_id_d      = rd1_id_q;
    rd2_v_d       = rd1_v_q;
    rd2_id_d      = rd1_id_q;
    if (xfer) begin
      ptr_d      = gnt_id;
      mem_addr_d = addr_arr[gnt_id];
      mem_wren_d = gnt_we;
      mem_rden_d = ~gnt_we;
      if (gnt_we) begin
        mem_wr_data_d = wdata_arr[gnt_id];
      end else begin
        rd1_v_d  = 1'b1;
        rd1_id_d = gnt_id;
      end
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  // The timeout wins over any owner transfer in the same cycle.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    lcnt_d         = lcnt_q;
    lock_timeout_d = 1'b0;
    case (state_q)
      ARB: begin
        if (xfer && lock[gnt_id]) begin
          state_d = LOCKED;
          owner_d = gnt_id;
          lcnt_d  = '0;
        end
      end
      LOCKED: begin
        if (lcnt_q == CW'(LOCK_MAX - 1)) begin
          state_d        = ARB;
          lcnt_d         = '0;
          lock_timeout_d = 1'b1;
        end else begin
          lcnt_d = lcnt_q + CW'(1);
          if (xfer && !lock[owner_q]) begin
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= IW'(NREQ - 1);
      mem_wren_q     <= 1'b0;
      mem_rden_q     <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      rd1_v_q        <= 1'b0;
      rd1_id_q       <= '0;
      rd2_v_q        <= 1'b0;
      rd2_id_q       <= '0;
`ifdef SRAM_ARB_LOCK_EN
      state_q        <= ARB;
      owner_q        <= '0;
      lcnt_q         <= '0;
      lock_timeout_q <= 1'b0;
`endif
    end else begin
      ptr_q          <= ptr_d;
      mem_wren_q     <= mem_wren_d;
      mem_rden_q     <= mem_rden_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      rd1_v_q        <= rd1_v_d;
      rd1_id_q       <= rd1_id_d;
      rd2_v_q        <= rd2_v_d;
      rd2_id_q       <= rd2_id_d;
`ifdef SRAM_ARB_LOCK_EN
      state_q        <= state_d;
      owner_q        <= owner_d;
      lcnt_q         <= lcnt_d;
      lock_timeout_q <= lock_timeout_d;
`endif
    end
  end

  always_comb begin
    rvalid = '0;
    if (rd2_v_q) begin
      rvalid[rd2_id_q] = 1'b1;
    end
  end

  assign rdata       = mem_rd_data;
  assign mem_wren    = mem_wren_q;
  assign mem_rden    = mem_rden_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
`ifdef SRAM_ARB_LOCK_EN
  assign lock_timeout = lock_timeout_q;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Testbench for sram_rr_arbiter: table-driven grant order, hand sequences, and random traffic
// checked against a behavioural round-robin/SRAM model. Lock tests run when SRAM_ARB_LOCK_EN is defined.
module tb_sram_rr_arbiter;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 1024;
  localparam int NREQ     = 4;
  localparam int AW       = 10;
  localparam int LOCK_MAX = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt, rvalid;
  logic [WIDTH-1:0]      rdata;
  logic                  mem_wren, mem_rden;
  logic [AW-1:0]         mem_addr;
  logic [WIDTH-1:0]      mem_wr_data, mem_rd_data;
`ifdef SRAM_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
  logic                  lock_timeout;
`endif

  always #5 clk = ~clk;

  sram_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef SRAM_ARB_LOCK_EN
    , .lock(lock), .lock_timeout(lock_timeout)
`endif
  );

  // Behavioural single-port SRAM with a registered read port
  logic [WIDTH-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_wren) sram[mem_addr] <= mem_wr_data;
    if (mem_rden) mem_rd_data <= sram[mem_addr];
  end

  typedef struct {
    int               due;
    int               id;
    logic [WIDTH-1:0] data;
  } rd_t;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
  } vec_t;

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               last;
  int               m_pick;
  int               waitc [NREQ];
  logic             known;
  logic             m_wren, m_rden;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_wdata;
  logic [WIDTH-1:0] shadow [DEPTH];
  rd_t              rq [$];
  logic [NREQ-1:0]  obs_gnt;
  vec_t             vecs [14];
  logic [NREQ*AW-1:0] addr_rr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pickModel(input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (last + i) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic rst_i, input logic [NREQ-1:0] req_i,
                               input logic [NREQ-1:0] we_i, input logic [NREQ*AW-1:0] addr_i,
                               input logic [NREQ*WIDTH-1:0] wdata_i);
    rst   = rst_i;
    req   = req_i;
    we    = we_i;
    addr  = addr_i;
    wdata = wdata_i;
  endtask

  task automatic checkOutput();
    logic [NREQ-1:0]  eg;
    logic [NREQ-1:0]  ev;
    logic [WIDTH-1:0] ed;
    int p;
    p  = rst ? -1 : pickModel(req);
    eg = '0;
    if (p >= 0) eg[p] = 1'b1;
    chk("gnt", gnt, eg);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    chk("wren_rden_excl", mem_wren & mem_rden, 0);
    ev = '0;
    ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev[rq[0].id] = 1'b1;
      ed = rq[0].data;
      void'(rq.pop_front());
    end
    if (known) begin
      chk("mem_wren", mem_wren, m_wren);
      chk("mem_rden", mem_rden, m_rden);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr_data", mem_wr_data, m_wdata);
      chk("rvalid", rvalid, ev);
      if (ev != '0) chk("rdata", rdata, ed);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (rst || !req[k] || gnt[k]) waitc[k] = 0;
      else waitc[k]++;
      if (req[k]) chk("fair_wait", waitc[k] >= NREQ, 0);
    end
    obs_gnt = gnt;
    m_pick  = p;
  endtask

  task automatic modelStep();
    int k;
    logic [AW-1:0] a;
    if (rst) begin
      known   = 1'b1;
      last    = NREQ - 1;
      m_wren  = 1'b0;
      m_rden  = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      rq.delete();
    end else if (m_pick >= 0) begin
      k      = m_pick;
      a      = addr[k*AW +: AW];
      last   = k;
      m_addr = a;
      m_wren = we[k];
      m_rden = !we[k];
      if (we[k]) begin
        m_wdata   = wdata[k*WIDTH +: WIDTH];
        shadow[a] = m_wdata;
      end else begin
        rq.push_back('{cyc + 2, k, shadow[a]});
      end
    end else begin
      m_wren = 1'b0;
      m_rden = 1'b0;
    end
    cyc++;
  endtask

  task automatic runCycle(input logic rst_i, input logic [NREQ-1:0] req_i,
                          input logic [NREQ-1:0] we_i, input logic [NREQ*AW-1:0] addr_i,
                          input logic [NREQ*WIDTH-1:0] wdata_i);
    applyStimulus(rst_i, req_i, we_i, addr_i, wdata_i);
    #2;
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) runCycle(1'b0, '0, '0, addr_rr, '0);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) runCycle(1'b1, '0, '0, '0, '0);
  endtask

`ifdef SRAM_ARB_LOCK_EN
  task automatic lockCycle(input string name, input logic [NREQ-1:0] req_i,
                           input logic [NREQ-1:0] lock_i, input logic [NREQ-1:0] exp_gnt,
                           input logic exp_to);
    rst  = 1'b0;
    req  = req_i;
    lock = lock_i;
    we   = '0;
    addr = addr_rr;
    #2;
    chk({name, "_gnt"}, gnt, exp_gnt);
    chk({name, "_timeout"}, lock_timeout, exp_to);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    logic [NREQ-1:0]       pend;
    logic [NREQ-1:0]       r_we;
    logic [AW-1:0]         r_addr [NREQ];
    logic [WIDTH-1:0]      r_wdata [NREQ];
    logic [NREQ-1:0]       rq_v;
    logic [NREQ*AW-1:0]    a_v;
    logic [NREQ*WIDTH-1:0] d_v;
    logic                  r_rst;

    for (int i = 0; i < DEPTH; i++) begin
      sram[i]   = 32'hA500_0000 ^ WIDTH'(i);
      shadow[i] = 32'hA500_0000 ^ WIDTH'(i);
    end
    for (int k = 0; k < NREQ; k++) begin
      addr_rr[k*AW +: AW] = AW'(k);
      waitc[k] = 0;
    end
    known = 1'b0;
    last  = NREQ - 1;
    rq.delete();
`ifdef SRAM_ARB_LOCK_EN
    lock = '0;
`endif

    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b1010, 4'b0010};
    vecs[6]  = '{4'b1010, 4'b1000};
    vecs[7]  = '{4'b0000, 4'b0000};
    vecs[8]  = '{4'b0110, 4'b0010};
    vecs[9]  = '{4'b0001, 4'b0001};
    vecs[10] = '{4'b1001, 4'b1000};
    vecs[11] = '{4'b1001, 4'b0001};
    vecs[12] = '{4'b0100, 4'b0100};
    vecs[13] = '{4'b1111, 4'b1000};

    doReset(2);
    for (int i = 0; i < 14; i++) begin
      runCycle(1'b0, vecs[i].req, '0, addr_rr, '0);
      chk($sformatf("vec%0d_gnt", i), obs_gnt, vecs[i].gnt);
    end
    idle(3);

    // Write then immediate read of the same address must return the new word
    a_v = '0;
    a_v[0 +: AW] = AW'(16);
    d_v = '0;
    d_v[0 +: WIDTH] = 32'hDEADBEEF;
    runCycle(1'b0, 4'b0001, 4'b0001, a_v, d_v);
    runCycle(1'b0, 4'b0001, 4'b0000, a_v, '0);
    idle(1);
    chk("wr_rd_rvalid", rvalid, 4'b0001);
    chk("wr_rd_rdata", rdata, 32'hDEADBEEF);
    idle(2);

    pend = '0;
    r_we = '0;
    for (int k = 0; k < NREQ; k++) begin
      r_addr[k]  = '0;
      r_wdata[k] = '0;
    end
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k]    = 1'b1;
          r_we[k]    = $urandom_range(0, 1) == 1;
          r_addr[k]  = AW'($urandom_range(0, 7));
          r_wdata[k] = $urandom;
        end
      end
      rq_v = pend;
      for (int k = 0; k < NREQ; k++) begin
        a_v[k*AW +: AW]       = r_addr[k];
        d_v[k*WIDTH +: WIDTH] = r_wdata[k];
      end
      r_rst = ($urandom_range(0, 99) == 0);
      runCycle(r_rst, rq_v, r_we & rq_v, a_v, d_v);
      if (m_pick >= 0) pend[m_pick] = 1'b0;
    end
    idle(3);

    // A read still in the pipe when reset hits must never return
    a_v = '0;
    a_v[0 +: AW] = AW'(5);
    runCycle(1'b0, 4'b0001, 4'b0000, a_v, '0);
    runCycle(1'b1, 4'b0000, 4'b0000, a_v, '0);
    chk("rst_flush_rvalid", rvalid, 4'b0000);
    runCycle(1'b0, 4'b1111, 4'b0000, addr_rr, '0);
    chk("rst_first_gnt", obs_gnt, 4'b0001);
    idle(3);

`ifdef SRAM_ARB_LOCK_EN
    doReset(2);
    lockCycle("lk_c1", 4'b0111, 4'b0010, 4'b0001, 1'b0);
    lockCycle("lk_c2", 4'b0111, 4'b0010, 4'b0010, 1'b0);
    lockCycle("lk_c3", 4'b0111, 4'b0010, 4'b0010, 1'b0);
    lockCycle("lk_c4", 4'b0111, 4'b0000, 4'b0010, 1'b0);
    lockCycle("lk_c5", 4'b0111, 4'b0000, 4'b0100, 1'b0);

    doReset(2);
    lockCycle("to_c1", 4'b0110, 4'b0010, 4'b0010, 1'b0);
    lockCycle("to_c2", 4'b0110, 4'b0010, 4'b0010, 1'b0);
    lockCycle("to_c3", 4'b0110, 4'b0010, 4'b0010, 1'b0);
    lockCycle("to_c4", 4'b0110, 4'b0010, 4'b0010, 1'b0);
    lockCycle("to_c5", 4'b0110, 4'b0010, 4'b0010, 1'b0);
    lockCycle("to_c6", 4'b0110, 4'b0010, 4'b0100, 1'b1);
    lockCycle("to_c7", 4'b0110, 4'b0010, 4'b0010, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
